ft601_rd_unpacker: RTL and testbench



---
 rtl/ft601_rd_unpacker.sv | 102 ++++++++++
 tb/tb_ft601_rd_unpacker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ft601_rd_unpacker.sv
// ft601_rd_unpacker
// Unpacks 32-bit FT601 read-buffer words (with per-byte enables) into an
// 8-bit valid/ready byte stream. Enabled lanes go out lowest first. The last
// byte of a short word (not all enables set) can be flagged with m_last.
//
// Optional build macro FT601_RD_UNPACK_STATS_EN adds byte_count (wrapping)
// and drop_count (saturating) statistics ports.
//
// Parameters:
//   LAST_ON_SHORT : 1 = flag the final byte of a short word on m_last
//   DROP_ZERO_BE  : 1 = discard zero-enable words, 0 = emit lane 0 for them

module ft601_rd_unpacker #(
  parameter bit LAST_ON_SHORT = 1'b1,
  parameter bit DROP_ZERO_BE  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] buf_data,
  input  logic [3:0]  buf_be,
  input  logic        buf_valid,
  output logic        buf_rd_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last
`ifdef FT601_RD_UNPACK_STATS_EN
  ,
  output logic [31:0] byte_count,
  output logic [15:0] drop_count
`endif
);

  logic [31:0] hold_data;
  logic [3:0]  hold_mask;
  logic        short_flag;

  logic [3:0]  low_bit;
  logic        mask_one_hot;
  logic [1:0]  lane_sel;
  logic        accept;

  // Isolate the lowest pending lane; a one-hot mask means the byte on the
  // output is the final one of the held word.
  assign low_bit      = hold_mask & (~hold_mask + 4'd1);
  assign mask_one_hot = (hold_mask != 4'd0) &&
                        ((hold_mask & (hold_mask - 4'd1)) == 4'd0);

  // Lane index of the lowest pending enable.
  always_comb begin
    lane_sel = 2'd0;
    if (hold_mask[0])      lane_sel = 2'd0;
    else if (hold_mask[1]) lane_sel = 2'd1;
    else if (hold_mask[2]) lane_sel = 2'd2;
    else if (hold_mask[3]) lane_sel = 2'd3;
  end

  assign m_valid = (hold_mask != 4'd0);
  assign m_data  = hold_data[{lane_sel, 3'b000} +: 8];
  assign m_last  = LAST_ON_SHORT && short_flag && mask_one_hot;
  assign accept  = m_valid && m_ready;

  // Refill when empty, or in the same cycle the last held byte is taken,
  // so a steady stream of full words runs at one byte per clock.
  assign buf_rd_en = buf_valid &&
                     ((hold_mask == 4'd0) || (mask_one_hot && m_ready));

  // Holding register: load on pop, otherwise retire the accepted lane.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_data  <= 32'd0;
      hold_mask  <= 4'd0;
      short_flag <= 1'b0;
    end else if (buf_rd_en) begin
      hold_data  <= buf_data;
      short_flag <= (buf_be != 4'hF);
      if (buf_be == 4'h0)
        hold_mask <= DROP_ZERO_BE ? 4'b0000 : 4'b0001;
      else
        hold_mask <= buf_be;
    end else if (accept) begin
      hold_mask <= hold_mask & ~low_bit;
    end
  end

`ifdef FT601_RD_UNPACK_STATS_EN
  // Statistics: bytes handed downstream and zero-enable words discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_count <= 32'd0;
      drop_count <= 16'd0;
    end else begin
      if (accept)
        byte_count <= byte_count + 32'd1;
      if (buf_rd_en && (buf_be == 4'h0) && DROP_ZERO_BE &&
          (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ft601_rd_unpacker.sv
// Directed bench for ft601_rd_unpacker. Two instances share one modelled
// FWFT buffer word list (each with its own read pointer): dut_a uses the
// default parameters, dut_b has LAST_ON_SHORT=0 and DROP_ZERO_BE=0.

module tb_ft601_rd_unpacker;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m_ready = 1'b0;

  logic [31:0] buf_data_a = 32'd0, buf_data_b = 32'd0;
  logic [3:0]  buf_be_a = 4'd0, buf_be_b = 4'd0;
  logic        buf_valid_a = 1'b0, buf_valid_b = 1'b0;
  logic        buf_rd_en_a, buf_rd_en_b;
  logic [7:0]  m_data_a, m_data_b;
  logic        m_valid_a, m_valid_b;
  logic        m_last_a, m_last_b;
`ifdef FT601_RD_UNPACK_STATS_EN
  logic [31:0] byte_count_a, byte_count_b;
  logic [15:0] drop_count_a, drop_count_b;
`endif

  // buffer model: word list written by stimulus, popped on buf_rd_en
  logic [31:0] mem_d [0:1023];
  logic [3:0]  mem_be [0:1023];
  int          wr_ptr = 0;
  int          rd_a = 0, rd_b = 0;
  int          nxt_a, nxt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ft601_rd_unpacker dut_a (
    .clk(clk), .resetn(resetn),
    .buf_data(buf_data_a), .buf_be(buf_be_a), .buf_valid(buf_valid_a),
    .buf_rd_en(buf_rd_en_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_last(m_last_a)
`ifdef FT601_RD_UNPACK_STATS_EN
    , .byte_count(byte_count_a), .drop_count(drop_count_a)
`endif
  );

  ft601_rd_unpacker #(.LAST_ON_SHORT(1'b0), .DROP_ZERO_BE(1'b0)) dut_b (
    .clk(clk), .resetn(resetn),
    .buf_data(buf_data_b), .buf_be(buf_be_b), .buf_valid(buf_valid_b),
    .buf_rd_en(buf_rd_en_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_last(m_last_b)
`ifdef FT601_RD_UNPACK_STATS_EN
    , .byte_count(byte_count_b), .drop_count(drop_count_b)
`endif
  );

  assign nxt_a = rd_a + (buf_rd_en_a ? 1 : 0);
  assign nxt_b = rd_b + (buf_rd_en_b ? 1 : 0);

  always @(posedge clk) begin
    rd_a        <= nxt_a;
    buf_valid_a <= (nxt_a != wr_ptr);
    buf_data_a  <= mem_d[nxt_a];
    buf_be_a    <= mem_be[nxt_a];
    rd_b        <= nxt_b;
    buf_valid_b <= (nxt_b != wr_ptr);
    buf_data_b  <= mem_d[nxt_b];
    buf_be_b    <= mem_be[nxt_b];
  end

  task automatic chk_val(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] be);
    mem_d[wr_ptr]  = d;
    mem_be[wr_ptr] = be;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [7:0] t1_data [0:7];
  logic [7:0] bp_data [0:11];
  logic       bp_rdy  [0:11];
  logic [7:0] b;
  logic [7:0] exp_b;
  int         cnt;
  int         errs;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_d[i]  = 32'd0;
      mem_be[i] = 4'd0;
    end
    t1_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bp_data = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33,
                8'h44, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // reset state
    tick();
    chk_val("rst_m_valid", m_valid_a, 0);
    chk_val("rst_m_data", m_data_a, 0);
    chk_val("rst_m_last", m_last_a, 0);
    chk_val("rst_rd_en", buf_rd_en_a, 0);
    resetn = 1'b1;
    tick();

    // two full words, no bubbles
    m_ready = 1'b1;
    push(32'h44332211, 4'hF);
    push(32'h88776655, 4'hF);
    tick();
    chk_val("full_pop_latency", buf_rd_en_a, 1);
    chk_val("full_no_byte_yet", m_valid_a, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_val($sformatf("full_valid%0d", i), m_valid_a, 1);
      chk_val($sformatf("full_data%0d", i), m_data_a, t1_data[i]);
      chk_val($sformatf("full_last%0d", i), m_last_a, 0);
      chk_val($sformatf("full_rden%0d", i), buf_rd_en_a, (i == 3) ? 1 : 0);
    end
    tick();
    chk_val("full_drained", m_valid_a, 0);

    // short word: two low lanes
    push(32'hDDCCBBAA, 4'b0011);
    tick();
    chk_val("short_pop", buf_rd_en_a, 1);
    tick();
    chk_val("short_d0", m_data_a, 8'hAA);
    chk_val("short_l0", m_last_a, 0);
    chk_val("short_b_d0", m_data_b, 8'hAA);
    tick();
    chk_val("short_d1", m_data_a, 8'hBB);
    chk_val("short_l1", m_last_a, 1);
    chk_val("short_b_l1", m_last_b, 0);
    tick();
    chk_val("short_drained", m_valid_a, 0);

    // sparse enables 1010
    push(32'hDDCCBBAA, 4'b1010);
    tick();
    chk_val("sparse_pop", buf_rd_en_a, 1);
    tick();
    chk_val("sparse_d0", m_data_a, 8'hBB);
    chk_val("sparse_l0", m_last_a, 0);
    tick();
    chk_val("sparse_d1", m_data_a, 8'hDD);
    chk_val("sparse_l1", m_last_a, 1);
    tick();
    chk_val("sparse_drained", m_valid_a, 0);

    // zero enables: dropped by dut_a, lane 0 emitted by dut_b
    push(32'hDDCCBBAA, 4'h0);
    tick();
    chk_val("zero_pop_a", buf_rd_en_a, 1);
    chk_val("zero_pop_b", buf_rd_en_b, 1);
    tick();
    chk_val("zero_a_no_byte", m_valid_a, 0);
    chk_val("zero_b_valid", m_valid_b, 1);
    chk_val("zero_b_data", m_data_b, 8'hAA);
    chk_val("zero_b_last", m_last_b, 0);
`ifdef FT601_RD_UNPACK_STATS_EN
    chk_val("zero_drop_count_a", drop_count_a, 1);
    chk_val("zero_drop_count_b", drop_count_b, 0);
`endif
    tick();
    chk_val("zero_b_drained", m_valid_b, 0);

    // backpressure with ready pattern 1,0,0,1,0,1,0,1,1...
    m_ready = 1'b0;
    push(32'h44332211, 4'hF);
    push(32'h88776655, 4'hF);
    tick();
    chk_val("bp_pop", buf_rd_en_a, 1);
    tick();
    for (int i = 0; i < 12; i++) begin
      m_ready = bp_rdy[i];
      #1;
      chk_val($sformatf("bp_data%0d", i), m_data_a, bp_data[i]);
      chk_val($sformatf("bp_rden%0d", i), buf_rd_en_a, (i == 7) ? 1 : 0);
      tick();
    end
    chk_val("bp_drained", m_valid_a, 0);

    // reset after the second byte of a full word
    m_ready = 1'b1;
    push(32'h44332211, 4'hF);
    push(32'h88776655, 4'hF);
    tick();
    tick();
    chk_val("rstmid_d0", m_data_a, 8'h11);
    tick();
    chk_val("rstmid_d1", m_data_a, 8'h22);
    tick();
    resetn = 1'b0;
    #1;
    chk_val("rstmid_valid", m_valid_a, 0);
    chk_val("rstmid_data", m_data_a, 0);
    #1;
    resetn = 1'b1;
    #1;
    chk_val("rstmid_repop", buf_rd_en_a, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_val($sformatf("rstmid_next%0d", i), m_data_a, t1_data[4 + i]);
    end
    tick();
    chk_val("rstmid_drained", m_valid_a, 0);
`ifdef FT601_RD_UNPACK_STATS_EN
    chk_val("rstmid_byte_count", byte_count_a, 4);
`endif

    // 1000 full words streamed at full rate
    for (int i = 0; i < 1000; i++) begin
      b = 8'(4 * i);
      mem_d[wr_ptr + i]  = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      mem_be[wr_ptr + i] = 4'hF;
    end
    wr_ptr = wr_ptr + 1000;
    cnt = 0;
    errs = 0;
    exp_b = 8'd0;
    for (int c = 0; c < 5000 && cnt < 4000; c++) begin
      tick();
      if (m_valid_a) begin
        if (m_data_a !== exp_b) errs++;
        exp_b = exp_b + 8'd1;
        cnt++;
      end
    end
    chk_val("stream_bytes", cnt, 4000);
    chk_val("stream_data_errs", errs, 0);
    tick();
    tick();
    chk_val("stream_drained", m_valid_a, 0);
`ifdef FT601_RD_UNPACK_STATS_EN
    chk_val("stream_byte_count", byte_count_a, 4004);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
